seg7_scan_periph: RTL and testbench



---
 rtl/seg7_scan_periph.sv | 180 ++++++++++++++++++
 tb/tb_seg7_scan_periph.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_periph.sv
// seg7_scan_periph
//
// Memory-mapped four-digit 7-segment display controller. The CPU stores a
// segment code together with a one-hot digit-select field into the DIGI
// register; the block keeps one code per digit and multiplexes the four
// digits in hardware. Each digit is lit for SCAN_CYCLES clocks, followed by
// GAP_CYCLES clocks with every anode off to avoid ghosting between digits.
//
// Register map:
//   BASE_ADDR     DIGI  write: [11:8] one-hot digit select, [7:0] segment code
//                             (active-low, bit 7 = dp); the whole word is kept
//                             and returned on read.
//   BASE_ADDR+4   CTRL  [0] scan enable, [1] blank (anodes off, scan continues)
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   Address    data-bus byte address (bits 1:0 ignored)
//   MemRead    read strobe
//   MemWrite   write strobe, sampled on the rising clk edge
//   WriteData  store data
//   ReadData   combinational read data, zero when no register is read
//   an_n       digit anodes, active-low, an_n[0] = digit 0 (registered)
//   seg_n      cathodes {dp,g,f,e,d,c,b,a}, active-low (registered)

module seg7_scan_periph #(
    parameter logic [31:0] BASE_ADDR   = 32'h40000010,
    parameter int          SCAN_CYCLES = 1000,
    parameter int          GAP_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [3:0]  an_n,
    output logic [7:0]  seg_n
);

    // The counter only has to reach the longer of the two slot lengths.
    localparam int MAX_CYC = (SCAN_CYCLES > GAP_CYCLES) ? SCAN_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [31:0]      CTRL_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [1:0]       idx_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       ctrl_reg;
    logic [31:0]      last_word_reg;
    logic [3:0][7:0]  digit_reg;

    logic       hit_digi;
    logic       hit_ctrl;
    logic       digi_we;
    logic       ctrl_we;
    logic [3:0] digit_we;

    // Byte lanes within a word are not decoded.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^Address[1:0];

    assign hit_digi = (Address[31:2] == BASE_ADDR[31:2]);
    assign hit_ctrl = (Address[31:2] == CTRL_ADDR[31:2]);
    assign digi_we  = MemWrite & hit_digi;
    assign ctrl_we  = MemWrite & hit_ctrl;

    // One write enable per digit buffer; several may fire on the same store.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit_we
            assign digit_we[gi] = digi_we & WriteData[8 + gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Bus-visible registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_word_reg <= 32'h0;
            ctrl_reg      <= 2'b01;
            digit_reg     <= {4{8'hFF}};
        end else begin
            if (digi_we) begin
                last_word_reg <= WriteData;
            end
            if (ctrl_we) begin
                ctrl_reg <= WriteData[1:0];
            end
            for (int d = 0; d < 4; d++) begin
                if (digit_we[d]) begin
                    digit_reg[d] <= WriteData[7:0];
                end
            end
        end
    end

    // Reads see the register contents before any write on the same edge.
    always_comb begin
        ReadData = 32'h0;
        if (MemRead && hit_digi) begin
            ReadData = last_word_reg;
        end else if (MemRead && hit_ctrl) begin
            ReadData = {30'b0, ctrl_reg};
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM. The output registers are loaded from the current state, so
    // the pins follow the state by one clock. seg_n reads the live digit
    // buffer, which lets a store to the lit digit show up one clock after
    // its write edge without disturbing the slot timing.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_SHOW;
            idx_reg   <= 2'd0;
            cnt_reg   <= '0;
            an_n      <= 4'hF;
            seg_n     <= 8'hFF;
        end else begin
            if (state_reg == ST_SHOW) begin
                an_n  <= ctrl_reg[1] ? 4'hF : ~(4'b0001 << idx_reg);
                seg_n <= digit_reg[idx_reg];
            end else begin
                an_n  <= 4'hF;
                seg_n <= 8'hFF;
            end

            if (!ctrl_reg[0]) begin
                // Disabling parks the scanner so re-enabling starts at digit 0.
                state_reg <= ST_OFF;
                idx_reg   <= 2'd0;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_SHOW: begin
                        if (cnt_reg == SCAN_LAST) begin
                            cnt_reg <= '0;
                            if (GAP_CYCLES == 0) begin
                                idx_reg <= idx_reg + 2'd1;
                            end else begin
                                state_reg <= ST_GAP;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_reg == GAP_LAST) begin
                            cnt_reg   <= '0;
                            idx_reg   <= idx_reg + 2'd1;
                            state_reg <= ST_SHOW;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_reg <= ST_SHOW;
                        idx_reg   <= 2'd0;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_periph.sv
// Testbench for seg7_scan_periph with SCAN_CYCLES=4, GAP_CYCLES=2 (24-cycle
// scan period). Bus transactions come from a table; display timing is
// compared against a phase model that starts on the first lit cycle.

module tb_seg7_scan_periph;

    localparam logic [31:0] DIGI = 32'h40000010;
    localparam logic [31:0] CTRL = 32'h40000014;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [3:0]  an_n;
    logic [7:0]  seg_n;

    seg7_scan_periph #(
        .BASE_ADDR  (32'h40000010),
        .SCAN_CYCLES(4),
        .GAP_CYCLES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .an_n     (an_n),
        .seg_n    (seg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          scan;
    } vec_t;

    typedef struct {
        int          at;
        logic        we;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } sched_t;

    vec_t   vecs [18];
    sched_t sched [$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mdig [4];
    logic       mblank;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic idle_bus();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
        if (addr[31:2] == 30'h10000004) begin
            for (int b = 0; b < 4; b++)
                if (data[8 + b]) mdig[b] = data[7:0];
        end else if (addr[31:2] == 30'h10000005) begin
            mblank = data[1];
        end
    endtask

    function automatic logic [3:0] exp_an(input int i, input logic blank);
        int p;
        p = i % 24;
        if ((p % 6) < 4 && !blank) return ~(4'b0001 << (p / 6));
        return 4'hF;
    endfunction

    function automatic logic [7:0] exp_seg(input int i);
        int p;
        p = i % 24;
        if ((p % 6) < 4) return mdig[p / 6];
        return 8'hFF;
    endfunction

    // Called at a negedge; leaves the bench at the next negedge.
    task automatic bus_op(input logic we, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp);
        MemWrite  = we;
        MemRead   = rd;
        Address   = addr;
        WriteData = wdata;
        #1;
        $display("bus we=%b rd=%b addr=%h wdata=%h rdata=%h exp=%h",
                 we, rd, addr, wdata, ReadData, exp);
        check("bus_rdata", ReadData, exp);
        @(posedge clk);
        #1;
        idle_bus();
        if (we) model_write(addr, wdata);
        @(negedge clk);
    endtask

    // Stop then re-enable scanning; returns on the first lit sample (phase 0).
    task automatic restart();
        bus_op(1'b1, 1'b0, CTRL, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("off_an", {28'h0, an_n}, 32'hF);
        check("off_seg", {24'h0, seg_n}, 32'hFF);
        @(negedge clk);
        check("off_an2", {28'h0, an_n}, 32'hF);
        bus_op(1'b1, 1'b0, CTRL, 32'h1, 32'h0);
        check("reen_an0", {28'h0, an_n}, 32'hF);
        @(negedge clk);
        check("reen_an1", {28'h0, an_n}, 32'hF);
        @(negedge clk);
    endtask

    // Checks n samples against the phase model, issuing scheduled bus ops.
    // A store issued in iteration j becomes visible on the pins at j+2.
    task automatic run_scan(input int n);
        bit found;
        for (int i = 0; i < n; i++) begin
            foreach (sched[k])
                if (sched[k].we && sched[k].at == i - 2) model_write(sched[k].addr, sched[k].data);
            check($sformatf("scan_an[%0d]", i), {28'h0, an_n}, {28'h0, exp_an(i, mblank)});
            check($sformatf("scan_seg[%0d]", i), {24'h0, seg_n}, {24'h0, exp_seg(i)});
            found = 0;
            foreach (sched[k]) begin
                if (sched[k].at == i && !found) begin
                    found     = 1;
                    MemWrite  = sched[k].we;
                    MemRead   = sched[k].rd;
                    Address   = sched[k].addr;
                    WriteData = sched[k].data;
                    #1;
                    $display("scan op i=%0d we=%b rd=%b addr=%h data=%h rdata=%h",
                             i, sched[k].we, sched[k].rd, sched[k].addr, sched[k].data, ReadData);
                    if (sched[k].rd) check("scan_rdata", ReadData, sched[k].exp);
                end
            end
            @(posedge clk);
            #1;
            idle_bus();
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //           we    rd    addr          wdata          exp            scan
        vecs[0]  = '{1'b0, 1'b1, CTRL,         32'h0,         32'h00000001, 0};
        vecs[1]  = '{1'b0, 1'b1, DIGI,         32'h0,         32'h00000000, 0};
        vecs[2]  = '{1'b1, 1'b1, DIGI,         32'h000008F9,  32'h00000000, 0};
        vecs[3]  = '{1'b1, 1'b0, DIGI,         32'h000001C0,  32'h00000000, 0};
        vecs[4]  = '{1'b0, 1'b1, DIGI,         32'h0,         32'h000001C0, 0};
        vecs[5]  = '{1'b0, 1'b1, 32'h40000013, 32'h0,         32'h000001C0, 0};
        vecs[6]  = '{1'b1, 1'b1, 32'h40000018, 32'hFFFFFFFF,  32'h00000000, 0};
        vecs[7]  = '{1'b0, 1'b1, CTRL,         32'h0,         32'h00000001, 0};
        vecs[8]  = '{1'b0, 1'b0, DIGI,         32'h00000F11,  32'h00000000, 0};
        vecs[9]  = '{1'b0, 1'b1, DIGI,         32'h0,         32'h000001C0, 24};
        vecs[10] = '{1'b1, 1'b1, DIGI,         32'h00000F92,  32'h000001C0, 0};
        vecs[11] = '{1'b0, 1'b1, DIGI,         32'h0,         32'h00000F92, 24};
        vecs[12] = '{1'b1, 1'b1, DIGI,         32'hABCDE0A4,  32'h00000F92, 0};
        vecs[13] = '{1'b0, 1'b1, DIGI,         32'h0,         32'hABCDE0A4, 24};
        vecs[14] = '{1'b1, 1'b1, CTRL,         32'h00000003,  32'h00000001, 0};
        vecs[15] = '{1'b0, 1'b1, CTRL,         32'h0,         32'h00000003, 0};
        vecs[16] = '{1'b1, 1'b1, CTRL,         32'h00000000,  32'h00000003, 0};
        vecs[17] = '{1'b0, 1'b1, CTRL,         32'h0,         32'h00000000, 0};

        for (int d = 0; d < 4; d++) mdig[d] = 8'hFF;
        mblank = 1'b0;
        idle_bus();

        // Reset state
        reset = 1'b1;
        #1;
        check("rst_an", {28'h0, an_n}, 32'hF);
        check("rst_seg", {24'h0, seg_n}, 32'hFF);
        MemRead = 1'b1;
        Address = CTRL;
        #1;
        check("rst_ctrl", ReadData, 32'h1);
        Address = DIGI;
        #1;
        check("rst_digi", ReadData, 32'h0);
        idle_bus();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Idle scan after reset: two full periods, all segments off.
        run_scan(48);

        // Register table with display checks after selected entries.
        for (int v = 0; v < 18; v++) begin
            bus_op(vecs[v].we, vecs[v].rd, vecs[v].addr, vecs[v].wdata, vecs[v].exp);
            if (vecs[v].scan > 0) begin
                restart();
                run_scan(vecs[v].scan);
            end
        end

        // Blank while scanning, CTRL readback, and a store to the lit digit.
        sched.push_back('{4,  1'b1, 1'b0, CTRL, 32'h00000003, 32'h0});
        sched.push_back('{8,  1'b0, 1'b1, CTRL, 32'h0,        32'h00000003});
        sched.push_back('{14, 1'b1, 1'b0, CTRL, 32'h00000001, 32'h0});
        sched.push_back('{25, 1'b1, 1'b0, DIGI, 32'h00000199, 32'h0});
        restart();
        run_scan(36);
        sched.delete();

        // Reset in the middle of digit 2's slot.
        check("pre_rst_an", {28'h0, an_n}, 32'hB);
        check("pre_rst_seg", {24'h0, seg_n}, {24'h0, mdig[2]});
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_an", {28'h0, an_n}, 32'hF);
        check("mid_rst_seg", {24'h0, seg_n}, 32'hFF);
        MemRead = 1'b1;
        Address = DIGI;
        #1;
        check("mid_rst_digi", ReadData, 32'h0);
        idle_bus();
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 4; d++) mdig[d] = 8'hFF;
        mblank = 1'b0;
        @(negedge clk);
        run_scan(24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
